adder_carry_pipe: RTL and testbench
===================================

// Module: adder_carry_pipe
// PURPOSE
//  Pipelined N-bit adder with carry-in/carry-out, split into STAGES segments.
//  Each segment adds SEG=N/STAGES bits per cycle and forwards its carry to the next stage.
//  Gives full-width additions at high clock rate on wide datapaths.
//  Operands and results use a valid/ready handshake on both sides so it can sit between
//  streaming blocks (ALU, accumulators, DSP chains).
// PARAMETERS
//  N       16  operand/result width in bits; N % STAGES must be 0
//  STAGES  4   number of pipeline stages (1..N); SEG = N/STAGES (localparam)
// PORTS
//  i_clk        in   1  clock, rising edge
//  i_reset      in   1  asynchronous, active-high reset
//  i_valid      in   1  operands on i_adder_a/i_adder_b/i_cin are valid
//  o_ready      out  1  block accepts operands this cycle
//  i_adder_a    in   N  operand A, unsigned (two's complement with overflow option)
//  i_adder_b    in   N  operand B
//  i_cin        in   1  carry-in
//  o_valid      out  1  o_adder_sum/o_cout/o_overflow are valid
//  i_ready      in   1  downstream accepts result this cycle
//  o_adder_sum  out  N  (A + B + cin) mod 2^N
//  o_cout       out  1  carry out of bit N-1
//  o_overflow   out  1  signed overflow; present only with ADDER_OVF_FLAG_EN
// BEHAVIOUR
//  - Reset: every stage valid bit = 0, every data/carry register = 0.
//    o_valid=0, o_adder_sum=0, o_cout=0, o_overflow=0; o_ready=1 once reset is released.
//  - Global advance: adv = !o_valid || i_ready; o_ready = adv.
//    No register changes when adv=0.
//  - Input transfer when i_valid && o_ready; the operand set enters stage 0 with its own valid bit.
//  - Stage k (0..STAGES-1):
//      {c_k, s_k} = a[k*SEG +: SEG] + b[k*SEG +: SEG] + c_(k-1), with c_(-1) = i_cin.
//    Upper operand segments travel in skew registers, so each stage sees its segment in the
//    correct cycle. Lower sum segments travel in deskew registers, so all N bits emerge together.
//  - Latency: exactly STAGES cycles from input transfer to o_valid with no backpressure.
//    Throughput 1 result/cycle. Results leave in issue order.
//  - Bubbles: an empty input cycle propagates as an invalid slot. Data registers of invalid
//    slots may update, but o_adder_sum/o_cout hold their last value while o_valid=0.
//  - Backpressure: when o_valid=1 and i_ready=0 the whole pipe freezes. Outputs stay stable
//    until the result is taken. No loss, no duplication.
//  - Simultaneous input and output transfer in the same cycle is legal: full-rate streaming.
//  - Wrap-around: sum is modulo 2^N. The carry ripples through every stage; the final
//    stage's carry is o_cout.
//  - Reset mid-operation: all in-flight results are discarded immediately (asynchronous),
//    with the outputs at their reset values.
//  - STAGES=1: a single registered adder, latency 1.
// CONFIGURATION
//  - ADDER_OVF_FLAG_EN defined:
//      adds port o_overflow, registered with the final stage.
//      o_overflow = carry into bit N-1 XOR carry out of bit N-1.
//  - Not defined: o_overflow port is absent and no logic is generated for it.
//  - All other behaviour is identical in both builds.
// TESTING  (N=16, STAGES=4 unless noted)
//  1. Assert i_reset, pulse one clock, release
//     -> o_valid=0, o_adder_sum=0x0000, o_cout=0, o_ready=1.
//  2. A=0x00FF, B=0x0001, cin=0 issued once, i_ready=1
//     -> exactly 4 cycles later o_valid=1 for 1 cycle; sum=0x0100, cout=0.
//  3. A=0xFFFF, B=0x0000, cin=1
//     -> sum=0x0000, cout=1 (carry crosses all 4 stages).
//  4. 8 back-to-back random operations, i_ready=1
//     -> 8 consecutive valid results, in order, matching the reference model. Also rerun with N=8, STAGES=1 and N=32, STAGES=8.
//  5. Full pipe, i_ready=0 for 3 cycles
//     -> o_ready=0, outputs stable. Then i_ready=1 -> stream resumes, no drop or duplicate.
//     Assert i_reset mid-stream -> o_valid=0 at once; no stale results after release.
//  6. With ADDER_OVF_FLAG_EN: 0x7FFF+0x0001 -> ovf=1, cout=0. 0xFFFF+0x0001 -> ovf=0, cout=1. 0x8000+0x8000 -> ovf=1, cout=1.

Source files
------------

// File: rtl/adder_carry_pipe.sv
// Pipelined N-bit adder: STAGES carry-chained SEG-bit segments with valid/ready flow control.
// Define ADDER_OVF_FLAG_EN to add the registered signed-overflow output o_overflow.
module adder_carry_pipe #(
    parameter int unsigned N      = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_adder_a,
    input  logic [N-1:0] i_adder_b,
    input  logic         i_cin,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_adder_sum,
`ifdef ADDER_OVF_FLAG_EN
    output logic         o_overflow,
`endif
    output logic         o_cout
);

    localparam int unsigned SEG  = N / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    logic              adv;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] c_d;

    // Per-stage operand skew registers and partial-sum deskew registers.
    logic [N-1:0] a_q  [STAGES];
    logic [N-1:0] b_q  [STAGES];
    logic [N-1:0] s_q  [STAGES];
    logic [N-1:0] a_in [STAGES];
    logic [N-1:0] b_in [STAGES];
    logic [N-1:0] s_in [STAGES];
    logic [N-1:0] s_d  [STAGES];

    assign o_valid     = vld_q[LAST];
    assign adv         = !o_valid || i_ready;
    assign o_ready     = adv;
    assign o_adder_sum = s_q[LAST];
    assign o_cout      = c_q[LAST];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG:0] seg_sum;

        if (k == 0) begin : g_head
            assign a_in[k] = i_adder_a;
            assign b_in[k] = i_adder_b;
            assign s_in[k] = '0;
            assign c_in[k] = i_cin;
            assign v_in[k] = i_valid;
        end else begin : g_link
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign s_in[k] = s_q[k-1];
            assign c_in[k] = c_q[k-1];
            assign v_in[k] = vld_q[k-1];
        end

        assign seg_sum = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]}
                       + {{SEG{1'b0}}, c_in[k]};
        // Segment k of the incoming partial sum is still zero, so OR acts as an insert.
        assign s_d[k]  = s_in[k] | (N'(seg_sum[SEG-1:0]) << (k * SEG));
        assign c_d[k]  = seg_sum[SEG];
    end

`ifdef ADDER_OVF_FLAG_EN
    logic ovf_q;
    logic ovf_d;

    // Carry into the MSB is recovered from the MSB operand and sum bits.
    assign ovf_d      = a_in[LAST][N-1] ^ b_in[LAST][N-1] ^ s_d[LAST][N-1] ^ c_d[LAST];
    assign o_overflow = ovf_q;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vld_q <= '0;
            c_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
`ifdef ADDER_OVF_FLAG_EN
            ovf_q <= 1'b0;
`endif
        end else if (adv) begin
            vld_q <= v_in;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
            end
            for (int k = 0; k < int'(LAST); k++) begin
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
            end
            // The output stage only loads real results, so outputs hold across bubbles.
            if (v_in[LAST]) begin
                s_q[LAST] <= s_d[LAST];
                c_q[LAST] <= c_d[LAST];
`ifdef ADDER_OVF_FLAG_EN
                ovf_q     <= ovf_d;
`endif
            end
        end
    end

endmodule

// File: tb/tb_adder_carry_pipe.sv
// Bench for adder_carry_pipe: directed vector table, streaming, backpressure and reset cases,
// with scoreboards on 16/4, 8/1 and 32/8 configurations.
module tb_adder_carry_pipe;

    localparam int N      = 16;
    localparam int STAGES = 4;
    localparam int NVEC   = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         valid_in, ready_out, valid_out, ready_in, cin, cout;
    logic [N-1:0] a, b, sum;
    logic         v8, rdy8, vo8, ri8, cin8, cout8;
    logic [7:0]   a8, b8, s8;
    logic         v32, rdy32, vo32, ri32, cin32, cout32;
    logic [31:0]  a32, b32, s32;
`ifdef ADDER_OVF_FLAG_EN
    logic         ovf, ovf8, ovf32;
`endif

    adder_carry_pipe #(.N(N), .STAGES(STAGES)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid_in), .o_ready(ready_out),
        .i_adder_a(a), .i_adder_b(b), .i_cin(cin), .o_valid(valid_out), .i_ready(ready_in),
        .o_adder_sum(sum),
`ifdef ADDER_OVF_FLAG_EN
        .o_overflow(ovf),
`endif
        .o_cout(cout)
    );

    adder_carry_pipe #(.N(8), .STAGES(1)) dut8 (
        .i_clk(clk), .i_reset(rst), .i_valid(v8), .o_ready(rdy8),
        .i_adder_a(a8), .i_adder_b(b8), .i_cin(cin8), .o_valid(vo8), .i_ready(ri8),
        .o_adder_sum(s8),
`ifdef ADDER_OVF_FLAG_EN
        .o_overflow(ovf8),
`endif
        .o_cout(cout8)
    );

    adder_carry_pipe #(.N(32), .STAGES(8)) dut32 (
        .i_clk(clk), .i_reset(rst), .i_valid(v32), .o_ready(rdy32),
        .i_adder_a(a32), .i_adder_b(b32), .i_cin(cin32), .o_valid(vo32), .i_ready(ri32),
        .o_adder_sum(s32),
`ifdef ADDER_OVF_FLAG_EN
        .o_overflow(ovf32),
`endif
        .o_cout(cout32)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboards: push the reference {cout,sum} on input transfer, pop on output transfer.
    logic [16:0] q16[$];
    logic [8:0]  q8[$];
    logic [32:0] q32[$];
    logic [16:0] e16;
    logic [8:0]  e8;
    logic [32:0] e32;
    int out16 = 0, out8 = 0, out32 = 0;

    always @(negedge clk) begin
        if (rst) begin
            q16.delete();
        end else begin
            if (valid_out && ready_in) begin
                out16++;
                if (q16.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb16_extra: unexpected result 0x%0h, none pending", sum);
                end else begin
                    e16 = q16.pop_front();
                    check("sb16_result", {cout, sum}, e16);
                end
            end
            if (valid_in && ready_out) q16.push_back({1'b0, a} + {1'b0, b} + 17'(cin));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q8.delete();
            q32.delete();
        end else begin
            if (vo8 && ri8) begin
                out8++;
                if (q8.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb8_extra: unexpected result 0x%0h, none pending", s8);
                end else begin
                    e8 = q8.pop_front();
                    check("sb8_result", {cout8, s8}, e8);
                end
            end
            if (vo32 && ri32) begin
                out32++;
                if (q32.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb32_extra: unexpected result 0x%0h, none pending", s32);
                end else begin
                    e32 = q32.pop_front();
                    check("sb32_result", {cout32, s32}, e32);
                end
            end
            if (v8 && rdy8) q8.push_back({1'b0, a8} + {1'b0, b8} + 9'(cin8));
            if (v32 && rdy32) q32.push_back({1'b0, a32} + {1'b0, b32} + 33'(cin32));
        end
    end

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t        vecs [NVEC];
    logic [15:0] bp_a [12];
    logic [15:0] bp_b [12];
    int          first, last, hits, idx, base16, base8, base32;
    logic [15:0] snap_sum;
    logic        snap_cout;

    initial begin
        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[7] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0};

        rst = 1'b1;
        valid_in = 1'b0; a = '0; b = '0; cin = 1'b0; ready_in = 1'b1;
        v8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; ri8 = 1'b1;
        v32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; ri32 = 1'b1;

        // Reset state
        #2;
        check("rst_hold_valid", valid_out, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", valid_out, 1'b0);
        check("rst_sum", sum, 16'h0000);
        check("rst_cout", cout, 1'b0);
        check("rst_ready", ready_out, 1'b1);

        // Single issues: exact latency, one-cycle pulse, value, hold across bubbles
        for (int i = 0; i < NVEC; i++) begin
            first = -1;
            hits  = 0;
            @(posedge clk); #1;
            valid_in = 1'b1; a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
            for (int cyc = 1; cyc <= STAGES + 2; cyc++) begin
                @(posedge clk); #1;
                valid_in = 1'b0; a = '0; b = '0; cin = 1'b0;
                @(negedge clk);
                if (valid_out) begin
                    hits++;
                    if (first < 0) begin
                        first = cyc;
                        check("vec_sum", sum, vecs[i].sum);
                        check("vec_cout", cout, vecs[i].cout);
`ifdef ADDER_OVF_FLAG_EN
                        check("vec_ovf", ovf, vecs[i].ovf);
`endif
                    end
                end
            end
            check("vec_latency", first, STAGES);
            check("vec_pulses", hits, 1);
            check("vec_hold_sum", sum, vecs[i].sum);
        end

        // Back-to-back streaming on all three configurations
        @(posedge clk); #1;
        base8 = out8; base32 = out32;
        first = -1; last = -1; hits = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            valid_in = (cyc < 8); v8 = (cyc < 8); v32 = (cyc < 8);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1));
            a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (valid_out) begin
                hits++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            @(posedge clk); #1;
        end
        check("stream_count", hits, 8);
        check("stream_contig", last - first + 1, 8);
        check("stream_latency", first, STAGES);
        check("stream8_count", out8 - base8, 8);
        check("stream32_count", out32 - base32, 8);
        check("stream8_pending", q8.size(), 0);
        check("stream32_pending", q32.size(), 0);

        // Backpressure: stall three cycles with the pipe full
        for (int i = 0; i < 12; i++) begin
            bp_a[i] = 16'($urandom);
            bp_b[i] = 16'($urandom);
        end
        base16 = out16;
        idx = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            valid_in = (idx < 12);
            if (idx < 12) begin
                a = bp_a[idx]; b = bp_b[idx]; cin = idx[0];
            end
            ready_in = !(cyc >= 6 && cyc <= 8);
            @(negedge clk);
            if (!ready_in) begin
                check("bp_ready_low", ready_out, 1'b0);
                if (cyc == 6) begin
                    snap_sum  = sum;
                    snap_cout = cout;
                    check("bp_full_valid", valid_out, 1'b1);
                end else begin
                    check("bp_sum_stable", sum, snap_sum);
                    check("bp_cout_stable", cout, snap_cout);
                    check("bp_valid_stable", valid_out, 1'b1);
                end
            end
            if (valid_in && ready_out) idx++;
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        check("bp_issued", idx, 12);
        check("bp_delivered", out16 - base16, 12);
        check("bp_pending", q16.size(), 0);

        // Reset in the middle of a stream
        for (int cyc = 0; cyc < 6; cyc++) begin
            valid_in = 1'b1;
            a = 16'($urandom) | 16'h0101; b = 16'($urandom); cin = 1'b1;
            @(posedge clk); #1;
        end
        check("rstmid_pre_valid", valid_out, 1'b1);
        rst = 1'b1;
        valid_in = 1'b0;
        #1;
        check("rstmid_valid", valid_out, 1'b0);
        check("rstmid_sum", sum, 16'h0000);
        check("rstmid_cout", cout, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        hits = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (valid_out) hits++;
            @(posedge clk); #1;
        end
        check("rstmid_no_stale", hits, 0);
        check("rstmid_ready", ready_out, 1'b1);

        check("final_pending16", q16.size(), 0);
        check("final_pending8", q8.size(), 0);
        check("final_pending32", q32.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
